// File: rtl/rxq_pkg.sv
// Shared definitions for the BLE receive-to-RAM writer: FSM encoding,
// default ring-buffer bounds and byte-lane constants.
package rxq_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // Also used by the top-level address decode to carve the ring out of RAM.
  localparam logic [31:0] ADR_LL_DEF = 32'h0000_0300;
  localparam logic [31:0] ADR_UL_DEF = 32'h0000_1FFC;

  localparam logic [3:0] SEL_ALL   = 4'b1111;
  localparam logic [3:0] SEL_LANE0 = 4'b0001;

  // Advance a ring pointer by step, falling back to base once past limit.
  function automatic logic [31:0] ring_next(input logic [31:0] ptr,
                                            input logic [31:0] step,
                                            input logic [31:0] limit,
                                            input logic [31:0] base);
    logic [31:0] nxt;
    nxt = ptr + step;
    return (nxt > limit) ? base : nxt;
  endfunction

endpackage

// File: rtl/ble_rx_writer_if.sv
// Wishbone write-master bundle between ble_rx_writer and the servant_ram mux.
interface ble_rx_writer_if;
  logic [31:0] o_wb_adr;
  logic        o_wb_cyc;
  logic        o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_dat;
  logic        i_wb_ack;

  modport master (output o_wb_adr, o_wb_cyc, o_wb_we, o_wb_sel, o_wb_dat,
                  input  i_wb_ack);
  modport slave  (input  o_wb_adr, o_wb_cyc, o_wb_we, o_wb_sel, o_wb_dat,
                  output i_wb_ack);
endinterface

// File: rtl/rxq_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module rxq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_pop;
  logic             do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ble_rx_writer.sv
// Drains received BLE bytes into a RAM ring buffer over Wishbone, only
// starting cycles while the CPU is off the bus. RXQ_PACK_EN packs bytes densely.
module ble_rx_writer
  import rxq_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] ADR_LL     = ADR_LL_DEF,
  parameter logic [31:0] ADR_UL     = ADR_UL_DEF
) (
  input  logic                          i_wb_clk,
  input  logic                          i_wb_rst,
  input  logic                          i_rx_done,
  input  logic [7:0]                    i_rx_dat,
  input  logic                          i_cpu_cyc,
  input  logic                          i_ovf_clr,
  ble_rx_writer_if.master               wb,
  output logic [31:0]                   o_wr_ptr,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow
);

`ifdef RXQ_PACK_EN
  localparam logic [31:0] PTR_STEP  = 32'd1;
  localparam logic [31:0] PTR_LIMIT = ADR_UL + 32'd3;
`else
  localparam logic [31:0] PTR_STEP  = 32'd4;
  localparam logic [31:0] PTR_LIMIT = ADR_UL;
`endif

  logic [0:0]  state_reg;
  logic        cyc_reg;
  logic [31:0] adr_reg;
  logic [3:0]  sel_reg;
  logic [31:0] dat_reg;
  logic [31:0] wr_ptr_reg;
  logic        overflow_reg;

  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  head_byte;
  logic        rx_drop;
  logic [31:0] req_adr;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;

  assign fifo_pop = (state_reg == ST_WRITE) && wb.i_wb_ack;
  assign rx_drop  = i_rx_done && fifo_full && !fifo_pop;

  rxq_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_wb_clk),
    .rst   (i_wb_rst),
    .push  (i_rx_done),
    .pop   (fifo_pop),
    .din   (i_rx_dat),
    .dout  (head_byte),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

`ifdef RXQ_PACK_EN
  assign req_adr = {wr_ptr_reg[31:2], 2'b00};
  assign req_sel = SEL_LANE0 << wr_ptr_reg[1:0];
  assign req_dat = {4{head_byte}};
`else
  assign req_adr = wr_ptr_reg;
  assign req_sel = SEL_ALL;
  assign req_dat = {24'h0, head_byte};
`endif

  // Bus outputs are only loaded on the IDLE->WRITE edge, so they stay
  // stable for the whole cycle regardless of CPU activity or new bytes.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_reg  <= ST_IDLE;
      cyc_reg    <= 1'b0;
      adr_reg    <= ADR_LL;
      sel_reg    <= 4'b0000;
      dat_reg    <= 32'h0;
      wr_ptr_reg <= ADR_LL;
    end else if (state_reg == ST_IDLE) begin
      if (!fifo_empty && !i_cpu_cyc) begin
        state_reg <= ST_WRITE;
        cyc_reg   <= 1'b1;
        adr_reg   <= req_adr;
        sel_reg   <= req_sel;
        dat_reg   <= req_dat;
      end
    end else if (wb.i_wb_ack) begin
      state_reg  <= ST_IDLE;
      cyc_reg    <= 1'b0;
      wr_ptr_reg <= ring_next(wr_ptr_reg, PTR_STEP, PTR_LIMIT, ADR_LL);
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      overflow_reg <= 1'b0;
    end else if (rx_drop) begin
      overflow_reg <= 1'b1;
    end else if (i_ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign wb.o_wb_cyc = cyc_reg;
  assign wb.o_wb_we  = cyc_reg;
  assign wb.o_wb_adr = adr_reg;
  assign wb.o_wb_sel = sel_reg;
  assign wb.o_wb_dat = dat_reg;
  assign o_wr_ptr    = wr_ptr_reg;
  assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_ble_rx_writer.sv
// Self-checking bench for ble_rx_writer: vector table, corner-case sequences
// and random traffic against a queue-based model (RXQ_PACK_EN-aware).
module tb_ble_rx_writer;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] ADR_LL = 32'h0000_0300;
  localparam logic [31:0] ADR_UL = 32'h0000_1FFC;
`ifdef RXQ_PACK_EN
  localparam int unsigned SLOTS = ADR_UL - ADR_LL + 4;
`else
  localparam int unsigned SLOTS = (ADR_UL - ADR_LL) / 4 + 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_done;
  logic [7:0]  rx_dat;
  logic        cpu_cyc;
  logic        ovf_clr;
  logic [31:0] wr_ptr;
  logic [3:0]  level;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  ble_rx_writer_if bus ();

  ble_rx_writer #(
    .FIFO_DEPTH (DEPTH),
    .ADR_LL     (ADR_LL),
    .ADR_UL     (ADR_UL)
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_rx_done  (rx_done),
    .i_rx_dat   (rx_dat),
    .i_cpu_cyc  (cpu_cyc),
    .i_ovf_clr  (ovf_clr),
    .wb         (bus),
    .o_wr_ptr   (wr_ptr),
    .o_level    (level),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  // RAM: registered one-cycle acknowledge.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.i_wb_ack <= 1'b0;
    else     bus.i_wb_ack <= bus.o_wb_cyc && !bus.i_wb_ack;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mq [$];
  int unsigned wcnt;
  logic        ovf_m;
  logic        cyc_m;
  logic [31:0] last_adr;
  logic [31:0] last_dat;

  function automatic logic [31:0] ptr_of(input int unsigned n);
`ifdef RXQ_PACK_EN
    return ADR_LL + (n % SLOTS);
`else
    return ADR_LL + 4 * (n % SLOTS);
`endif
  endfunction

  initial begin : monitor
    logic [7:0]  b;
    logic [31:0] p;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
    logic [3:0]  e_sel;
    logic        popped;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        wcnt  = 0;
        ovf_m = 1'b0;
        cyc_m = 1'b0;
      end else begin
        chk("level",    32'(level),        32'(mq.size()));
        chk("overflow", 32'(overflow),     32'(ovf_m));
        chk("wr_ptr",   wr_ptr,            ptr_of(wcnt));
        chk("cyc",      32'(bus.o_wb_cyc), 32'(cyc_m));
        chk("we",       32'(bus.o_wb_we),  32'(bus.o_wb_cyc));
        popped = bus.o_wb_cyc && bus.i_wb_ack;
        // Owner holds the bus until ack; otherwise a request follows any
        // cycle that saw a queued byte with the CPU off the bus.
        cyc_m = bus.o_wb_cyc ? !bus.i_wb_ack : (!cpu_cyc && mq.size() != 0);
        if (popped) begin
          chk("pop_nonempty", 32'(mq.size() != 0), 32'd1);
          if (mq.size() != 0) begin
            b = mq.pop_front();
            p = ptr_of(wcnt);
`ifdef RXQ_PACK_EN
            e_adr = {p[31:2], 2'b00};
            e_sel = 4'b0001 << p[1:0];
            e_dat = {4{b}};
`else
            e_adr = p;
            e_sel = 4'hF;
            e_dat = {24'h0, b};
`endif
            chk("ram_adr", bus.o_wb_adr,       e_adr);
            chk("ram_sel", 32'(bus.o_wb_sel),  32'(e_sel));
            chk("ram_dat", bus.o_wb_dat,       e_dat);
            last_adr = bus.o_wb_adr;
            last_dat = bus.o_wb_dat;
            wcnt++;
          end
        end
        if (rx_done && mq.size() >= DEPTH) ovf_m = 1'b1;
        else if (ovf_clr)                  ovf_m = 1'b0;
        if (rx_done && mq.size() < DEPTH)  mq.push_back(rx_dat);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input logic v, input int lim, input string name);
    int n = 0;
    while (bus.o_wb_cyc !== v && n < lim) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.o_wb_cyc), 32'(v));
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((mq.size() != 0 || bus.o_wb_cyc) && n < lim) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(mq.size()), 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_dat  = d;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  dat;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] ptr;
  } vec_t;

  vec_t vecs [5];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
`ifdef RXQ_PACK_EN
    vecs[0] = '{8'h01, 32'h300, 4'h1, 32'h0101_0101, 32'h301};
    vecs[1] = '{8'h02, 32'h300, 4'h2, 32'h0202_0202, 32'h302};
    vecs[2] = '{8'h03, 32'h300, 4'h4, 32'h0303_0303, 32'h303};
    vecs[3] = '{8'h04, 32'h300, 4'h8, 32'h0404_0404, 32'h304};
    vecs[4] = '{8'h05, 32'h304, 4'h1, 32'h0505_0505, 32'h305};
`else
    vecs[0] = '{8'hA5, 32'h300, 4'hF, 32'h0000_00A5, 32'h304};
    vecs[1] = '{8'h3C, 32'h304, 4'hF, 32'h0000_003C, 32'h308};
    vecs[2] = '{8'h00, 32'h308, 4'hF, 32'h0000_0000, 32'h30C};
    vecs[3] = '{8'hFF, 32'h30C, 4'hF, 32'h0000_00FF, 32'h310};
    vecs[4] = '{8'h5A, 32'h310, 4'hF, 32'h0000_005A, 32'h314};
`endif
    rst = 1'b1; rx_done = 1'b0; rx_dat = 8'h00; cpu_cyc = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_cyc",   32'(bus.o_wb_cyc), 32'd0);
    chk("rst_we",    32'(bus.o_wb_we),  32'd0);
    chk("rst_sel",   32'(bus.o_wb_sel), 32'd0);
    chk("rst_dat",   bus.o_wb_dat,      32'd0);
    chk("rst_adr",   bus.o_wb_adr,      32'h300);
    chk("rst_ptr",   wr_ptr,            32'h300);
    chk("rst_level", 32'(level),        32'd0);
    chk("rst_ovf",   32'(overflow),     32'd0);

    // Vector table: one byte per transaction, 1-cycle ack RAM.
    for (int i = 0; i < 5; i++) begin
      push_byte(vecs[i].dat);
      wait_cyc(1'b1, 10, "tbl_req");
      chk("tbl_adr", bus.o_wb_adr,      vecs[i].adr);
      chk("tbl_sel", 32'(bus.o_wb_sel), 32'(vecs[i].sel));
      chk("tbl_dat", bus.o_wb_dat,      vecs[i].wdat);
      wait_cyc(1'b0, 10, "tbl_done");
      chk("tbl_ptr",   wr_ptr,     vecs[i].ptr);
      chk("tbl_level", 32'(level), 32'd0);
      $display("vec %0d byte=%h adr=%h sel=%h ptr=%h", i, vecs[i].dat, last_adr, vecs[i].sel, wr_ptr);
    end

    // CPU contention: three bytes arrive while the CPU holds the bus.
    cpu_cyc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_done = (i == 2 || i == 5 || i == 8);
      rx_dat  = 8'h40 + 8'(i);
      tick();
      chk("hold_cyc", 32'(bus.o_wb_cyc), 32'd0);
    end
    rx_done = 1'b0;
    chk("hold_level", 32'(level), 32'd3);
    cpu_cyc = 1'b0;
    drain(60);
    $display("contention drained ptr=%h", wr_ptr);

    // Overflow: nine bytes into an eight-entry FIFO with the CPU on the bus.
    cpu_cyc = 1'b1;
    for (int i = 0; i < 9; i++) push_byte(8'h80 + 8'(i));
    chk("ovf_level", 32'(level),    32'd8);
    chk("ovf_set",   32'(overflow), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    ovf_clr = 1'b1; rx_done = 1'b1; rx_dat = 8'hEE; tick();
    ovf_clr = 1'b0; rx_done = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 32'd0);
    $display("overflow level=%0d", level);

    // Full FIFO: a byte arriving with the ack is accepted.
    cpu_cyc = 1'b0;
    n = 0;
    while (bus.i_wb_ack !== 1'b1 && n < 10) begin tick(); n++; end
    chk("fullpop_ack", 32'(bus.i_wb_ack), 32'd1);
    push_byte(8'h77);
    chk("fullpop_level", 32'(level),    32'd8);
    chk("fullpop_ovf",   32'(overflow), 32'd0);
    drain(100);
    $display("full-with-pop drained ptr=%h", wr_ptr);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rx_done = ($urandom_range(2) == 0);
      rx_dat  = 8'($urandom);
      if ($urandom_range(15) == 0) cpu_cyc = !cpu_cyc;
      ovf_clr = ($urandom_range(19) == 0);
      tick();
    end
    rx_done = 1'b0; ovf_clr = 1'b0; cpu_cyc = 1'b0;
    drain(100);
    $display("random done writes=%0d ptr=%h", wcnt, wr_ptr);

    // Walk the ring up to its last slot, then write 8'h11 there.
    n = 0;
    while (ptr_of(wcnt + mq.size()) != 32'h1FFC && n < 40000) begin
      rx_done = (mq.size() < 4);
      rx_dat  = 8'($urandom);
      tick();
      n++;
    end
    rx_done = 1'b0;
    drain(100);
    push_byte(8'h11);
    drain(20);
    chk("wrap_adr", last_adr, 32'h1FFC);
`ifdef RXQ_PACK_EN
    chk("wrap_dat", last_dat, 32'h1111_1111);
    chk("wrap_ptr", wr_ptr,   32'h1FFD);
`else
    chk("wrap_dat", last_dat, 32'h0000_0011);
    chk("wrap_ptr", wr_ptr,   32'h300);
`endif
    $display("wrap adr=%h ptr=%h", last_adr, wr_ptr);

    // Asynchronous reset in the middle of a write.
    push_byte(8'hAB);
    push_byte(8'hCD);
    wait_cyc(1'b1, 10, "rst_mid_req");
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_cyc",   32'(bus.o_wb_cyc), 32'd0);
    chk("rst_mid_we",    32'(bus.o_wb_we),  32'd0);
    chk("rst_mid_ptr",   wr_ptr,            32'h300);
    chk("rst_mid_level", 32'(level),        32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_after_cyc", 32'(bus.o_wb_cyc), 32'd0);
    $display("reset mid-write ptr=%h level=%0d", wr_ptr, level);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
